// File: rtl/ide_pio_xfer_if.sv
// Host-side PIO handshake and sector-buffer port bundle for ide_pio_xfer.
// The slave modport is the transfer engine; the master modport is the host/buffer side.
interface ide_pio_xfer_if #(
    parameter int ADDR_W = 9
);
    // Host control and data-register strobes
    logic              start;
    logic              dir;
    logic [ADDR_W:0]   count;
    logic              abort;
    logic              rd_strobe;
    logic              wr_strobe;
    logic [15:0]       wr_data;
    logic [15:0]       rd_data;
    logic              drq;
    logic              busy;
    logic              done;
    logic              err;

    // Sector buffer port (read data returns one cycle after the address)
    logic [ADDR_W-1:0] buf_read_addr;
    logic [15:0]       buf_read_data;
    logic [ADDR_W-1:0] buf_write_addr;
    logic [15:0]       buf_write_data;
    logic              buf_write_hi;
    logic              buf_write_lo;

    modport master (
        output start, dir, count, abort, rd_strobe, wr_strobe, wr_data, buf_read_data,
        input  rd_data, drq, busy, done, err,
        input  buf_read_addr, buf_write_addr, buf_write_data, buf_write_hi, buf_write_lo
    );

    modport slave (
        input  start, dir, count, abort, rd_strobe, wr_strobe, wr_data, buf_read_data,
        output rd_data, drq, busy, done, err,
        output buf_read_addr, buf_write_addr, buf_write_data, buf_write_hi, buf_write_lo
    );
endinterface

// File: rtl/ide_pio_xfer.sv
// PIO data-register engine: streams words between the host data register and a
// sector buffer, raising drq whenever a word (read) or space (write) is available.
module ide_pio_xfer #(
    parameter int ADDR_W = 9
) (
    input  logic          clk,
    input  logic          rst,
    ide_pio_xfer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_RD_READY,
        S_WR_READY
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] index_q;
    logic [ADDR_W:0]   remain_q;
    logic [15:0]       rd_data_q;
    logic              drq_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              wr_en_q;

    logic [ADDR_W-1:0] index_d;
    logic [ADDR_W:0]   remain_d;
    logic [ADDR_W:0]   start_remain_d;
    logic              last_word_d;
    logic              any_strobe_d;

    // Index wraps naturally at 2^ADDR_W; a zero count means a full buffer.
    always_comb begin
        index_d        = index_q + 1'b1;
        remain_d       = remain_q - 1'b1;
        start_remain_d = (bus.count == '0) ? {1'b1, {ADDR_W{1'b0}}} : bus.count;
        last_word_d    = (remain_q == (ADDR_W+1)'(1));
        any_strobe_d   = bus.rd_strobe | bus.wr_strobe;
    end

    // NOTE: every register here is a plain flop reset to a known value; sequential
    // state uses non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            remain_q  <= '0;
            rd_data_q <= '0;
            drq_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_addr_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= 1'b0;

            if (bus.abort) begin
                // Abort wins over any strobe or start in the same cycle; err is kept.
                state_q <= S_IDLE;
                drq_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.start) begin
                            err_q    <= 1'b0;
                            index_q  <= '0;
                            remain_q <= start_remain_d;
                            busy_q   <= 1'b1;
                            if (bus.dir) begin
                                state_q   <= S_FETCH;
                                rd_addr_q <= '0;
                            end else begin
                                state_q <= S_WR_READY;
                                drq_q   <= 1'b1;
                            end
                        end
                    end

                    S_FETCH: begin
                        state_q <= S_WAIT;
                        if (any_strobe_d) err_q <= 1'b1;
                    end

                    S_WAIT: begin
                        state_q   <= S_RD_READY;
                        rd_data_q <= bus.buf_read_data;
                        drq_q     <= 1'b1;
                        if (any_strobe_d) err_q <= 1'b1;
                    end

                    S_RD_READY: begin
                        if (bus.rd_strobe) begin
                            drq_q    <= 1'b0;
                            index_q  <= index_d;
                            remain_q <= remain_d;
                            if (last_word_d) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q   <= S_FETCH;
                                rd_addr_q <= index_d;
                            end
                        end
                    end

                    S_WR_READY: begin
                        if (bus.wr_strobe) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= index_q;
                            wr_data_q <= bus.wr_data;
                            index_q   <= index_d;
                            remain_q  <= remain_d;
                            if (last_word_d) begin
                                state_q <= S_IDLE;
                                drq_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                        drq_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.rd_data        = rd_data_q;
    assign bus.drq            = drq_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
    assign bus.buf_read_addr  = rd_addr_q;
    assign bus.buf_write_addr = wr_addr_q;
    assign bus.buf_write_data = wr_data_q;
    assign bus.buf_write_hi   = wr_en_q;
    assign bus.buf_write_lo   = wr_en_q;
endmodule

// File: tb/tb_ide_pio_xfer.sv
// Self-checking bench for ide_pio_xfer: a buffer model plus a word-level reference
// of buffer contents, driven with directed and randomized PIO transfers.
module tb_ide_pio_xfer;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;

    ide_pio_xfer_if #(.ADDR_W(ADDR_W)) bus ();

    ide_pio_xfer #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Sector buffer: registered read, write when both byte enables are set
    logic [15:0] buf_mem [DEPTH];
    always @(posedge clk) begin
        bus.buf_read_data <= buf_mem[bus.buf_read_addr];
        if (bus.buf_write_hi && bus.buf_write_lo)
            buf_mem[bus.buf_write_addr] <= bus.buf_write_data;
    end

    // Reference: what each buffer word should hold, and words to be written
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] stim    [DEPTH];

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if ({bus.drq, bus.busy, bus.done, bus.err} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b exp 0000", {bus.drq, bus.busy, bus.done, bus.err}); end
        n_cmp++; if (bus.rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h exp 0000", bus.rd_data); end
        n_cmp++; if ({bus.buf_write_hi, bus.buf_write_lo} !== 2'b00) begin n_bad++; $display("FAIL reset_wr_en: got %b exp 00", {bus.buf_write_hi, bus.buf_write_lo}); end
        n_cmp++; if ({bus.buf_read_addr, bus.buf_write_addr} !== '0) begin n_bad++; $display("FAIL reset_addrs: got %h/%h exp 0/0", bus.buf_read_addr, bus.buf_write_addr); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if ({bus.drq, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL reset_idle: got %b exp 00", {bus.drq, bus.busy}); end
    endtask

    // Read n words; expected data comes from ref_mem starting at index 0
    task automatic do_read(input int n, input logic [ADDR_W:0] cnt, input int max_gap);
        int lat;
        logic [ADDR_W-1:0] a;
        logic [15:0] held;
        bus.start = 1'b1; bus.dir = 1'b1; bus.count = cnt;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin n_bad++; $display("FAIL rd_start: busy/err got %b%b exp 10", bus.busy, bus.err); end
        for (int w = 0; w < n; w++) begin
            lat = 1;
            while (bus.drq !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
            n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rd_latency: word %0d got %0d edges exp 3", w, lat); end
            a = ADDR_W'(w);
            n_cmp++; if (bus.rd_data !== ref_mem[a]) begin n_bad++; $display("FAIL rd_data: word %0d got %h exp %h", w, bus.rd_data, ref_mem[a]); end
            n_cmp++; if (bus.buf_read_addr !== a) begin n_bad++; $display("FAIL rd_addr: word %0d got %0d exp %0d", w, bus.buf_read_addr, a); end
            held = bus.rd_data;
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
            n_cmp++; if (bus.drq !== 1'b1 || bus.rd_data !== held) begin n_bad++; $display("FAIL rd_hold: drq %b data %h exp 1 %h", bus.drq, bus.rd_data, held); end
            bus.rd_strobe = 1'b1;
            @(negedge clk);
            bus.rd_strobe = 1'b0;
            n_cmp++; if (bus.drq !== 1'b0) begin n_bad++; $display("FAIL rd_drq_drop: got %b exp 0", bus.drq); end
            n_cmp++; if (bus.done !== (w == n - 1) || bus.busy !== (w != n - 1)) begin n_bad++; $display("FAIL rd_done_busy: word %0d got %b%b exp %b%b", w, bus.done, bus.busy, (w == n - 1), (w != n - 1)); end
        end
        @(negedge clk);
        n_cmp++; if ({bus.done, bus.busy, bus.err} !== 3'b000) begin n_bad++; $display("FAIL rd_end: done/busy/err got %b exp 000", {bus.done, bus.busy, bus.err}); end
        a = ADDR_W'(n - 1);
        n_cmp++; if (bus.rd_data !== ref_mem[a]) begin n_bad++; $display("FAIL rd_data_hold_idle: got %h exp %h", bus.rd_data, ref_mem[a]); end
    endtask

    // Write n words from stim[]; each accepted word updates the reference buffer
    task automatic do_write(input int n, input logic [ADDR_W:0] cnt, input int max_gap);
        logic [ADDR_W-1:0] a;
        logic last;
        bus.start = 1'b1; bus.dir = 1'b0; bus.count = cnt;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if ({bus.drq, bus.busy, bus.err} !== 3'b110) begin n_bad++; $display("FAIL wr_start: drq/busy/err got %b exp 110", {bus.drq, bus.busy, bus.err}); end
        for (int w = 0; w < n; w++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge clk);
                n_cmp++; if ({bus.buf_write_hi, bus.buf_write_lo, bus.done} !== 3'b000) begin n_bad++; $display("FAIL wr_gap: en/done got %b exp 000", {bus.buf_write_hi, bus.buf_write_lo, bus.done}); end
            end
            bus.wr_strobe = 1'b1; bus.wr_data = stim[w];
            @(negedge clk);
            bus.wr_strobe = 1'b0; bus.wr_data = 16'($urandom);
            a = ADDR_W'(w);
            last = (w == n - 1);
            n_cmp++; if ({bus.buf_write_hi, bus.buf_write_lo} !== 2'b11) begin n_bad++; $display("FAIL wr_en: word %0d got %b exp 11", w, {bus.buf_write_hi, bus.buf_write_lo}); end
            n_cmp++; if (bus.buf_write_addr !== a || bus.buf_write_data !== stim[w]) begin n_bad++; $display("FAIL wr_addr_data: word %0d got %0d/%h exp %0d/%h", w, bus.buf_write_addr, bus.buf_write_data, a, stim[w]); end
            n_cmp++; if ({bus.done, bus.drq, bus.busy} !== {last, !last, !last}) begin n_bad++; $display("FAIL wr_done_drq_busy: word %0d got %b exp %b", w, {bus.done, bus.drq, bus.busy}, {last, !last, !last}); end
            ref_mem[a] = stim[w];
        end
        @(negedge clk);
        n_cmp++; if ({bus.buf_write_hi, bus.buf_write_lo, bus.done, bus.busy} !== 4'b0000) begin n_bad++; $display("FAIL wr_end: en/done/busy got %b exp 0000", {bus.buf_write_hi, bus.buf_write_lo, bus.done, bus.busy}); end
    endtask

    task automatic test_read_basic();
        buf_mem[0] = 16'h1111; buf_mem[1] = 16'h2222; buf_mem[2] = 16'h3333;
        ref_mem[0] = 16'h1111; ref_mem[1] = 16'h2222; ref_mem[2] = 16'h3333;
        do_read(3, 10'd3, 2);
    endtask

    task automatic test_write_basic();
        stim[0] = 16'hABCD; stim[1] = 16'h1234;
        do_write(2, 10'd2, 2);
    endtask

    task automatic test_full_buffer();
        for (int i = 0; i < DEPTH; i++) stim[i] = 16'($urandom);
        do_write(DEPTH, '0, 0);
        do_read(DEPTH, '0, 0);
        stim[0] = 16'($urandom);
        do_write(1, 10'd1, 0);
    endtask

    task automatic test_err();
        int lat;
        bus.start = 1'b1; bus.dir = 1'b1; bus.count = 10'd2;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.drq !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
        bus.rd_strobe = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.err !== 1'b0 || bus.drq !== 1'b0) begin n_bad++; $display("FAIL err_valid_strobe: err/drq got %b%b exp 00", bus.err, bus.drq); end
        @(negedge clk);
        bus.rd_strobe = 1'b0;
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b exp 1", bus.err); end
        lat = 2;
        while (bus.drq !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
        n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL err_latency: got %0d exp 3", lat); end
        n_cmp++; if (bus.rd_data !== ref_mem[1]) begin n_bad++; $display("FAIL err_index_kept: got %h exp %h", bus.rd_data, ref_mem[1]); end
        bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0;
        n_cmp++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin n_bad++; $display("FAIL err_persist: done/err got %b%b exp 11", bus.done, bus.err); end
        bus.rd_strobe = 1'b1; bus.wr_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0; bus.wr_strobe = 1'b0;
        n_cmp++; if ({bus.err, bus.buf_write_hi, bus.busy} !== 3'b100) begin n_bad++; $display("FAIL err_idle_strobe: err/en/busy got %b exp 100", {bus.err, bus.buf_write_hi, bus.busy}); end
        stim[0] = 16'($urandom);
        do_write(1, 10'd1, 1);
        bus.rd_strobe = 1'b1; bus.wr_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0; bus.wr_strobe = 1'b0;
        n_cmp++; if ({bus.err, bus.buf_write_hi} !== 2'b00) begin n_bad++; $display("FAIL err_idle_clean: err/en got %b exp 00", {bus.err, bus.buf_write_hi}); end
    endtask

    task automatic test_start_busy();
        stim[0] = 16'($urandom); stim[1] = 16'($urandom);
        bus.start = 1'b1; bus.dir = 1'b0; bus.count = 10'd2;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_strobe = 1'b1; bus.wr_data = stim[0];
        @(negedge clk);
        bus.wr_strobe = 1'b0;
        ref_mem[0] = stim[0];
        bus.start = 1'b1; bus.dir = 1'b1; bus.count = 10'd5;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if ({bus.drq, bus.busy, bus.buf_write_hi} !== 3'b110) begin n_bad++; $display("FAIL start_busy_ignored: drq/busy/en got %b exp 110", {bus.drq, bus.busy, bus.buf_write_hi}); end
        bus.wr_strobe = 1'b1; bus.wr_data = stim[1];
        @(negedge clk);
        bus.wr_strobe = 1'b0;
        n_cmp++; if ({bus.buf_write_hi, bus.done} !== 2'b11 || bus.buf_write_addr !== 9'd1) begin n_bad++; $display("FAIL start_busy_second: en/done %b addr %0d exp 11 1", {bus.buf_write_hi, bus.done}, bus.buf_write_addr); end
        ref_mem[1] = stim[1];
        @(negedge clk);
    endtask

    task automatic test_abort();
        stim[0] = 16'($urandom);
        bus.start = 1'b1; bus.dir = 1'b0; bus.count = 10'd4;
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_strobe = 1'b1; bus.wr_data = stim[0];
        @(negedge clk);
        ref_mem[0] = stim[0];
        bus.wr_data = 16'hDEAD; bus.abort = 1'b1;
        @(negedge clk);
        bus.wr_strobe = 1'b0; bus.abort = 1'b0;
        n_cmp++; if ({bus.buf_write_hi, bus.buf_write_lo} !== 2'b00) begin n_bad++; $display("FAIL abort_wr_suppressed: got %b exp 00", {bus.buf_write_hi, bus.buf_write_lo}); end
        n_cmp++; if ({bus.drq, bus.busy, bus.done} !== 3'b000) begin n_bad++; $display("FAIL abort_flags: drq/busy/done got %b exp 000", {bus.drq, bus.busy, bus.done}); end
        @(negedge clk);
        n_cmp++; if ({bus.done, bus.buf_write_hi} !== 2'b00) begin n_bad++; $display("FAIL abort_no_done: got %b exp 00", {bus.done, bus.buf_write_hi}); end
        bus.start = 1'b1; bus.dir = 1'b1; bus.count = 10'd2;
        @(negedge clk);
        bus.start = 1'b0; bus.rd_strobe = 1'b1;
        @(negedge clk);
        bus.rd_strobe = 1'b0; bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.err, bus.busy, bus.drq} !== 3'b100) begin n_bad++; $display("FAIL abort_err_kept: err/busy/drq got %b exp 100", {bus.err, bus.busy, bus.drq}); end
    endtask

    task automatic test_random();
        int n;
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 24);
            if ($urandom_range(0, 1) == 1) begin
                do_read(n, (ADDR_W+1)'(n), 2);
            end else begin
                for (int i = 0; i < n; i++) stim[i] = 16'($urandom);
                do_write(n, (ADDR_W+1)'(n), 2);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.start = 1'b1; bus.dir = 1'b1; bus.count = 10'd4;
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (bus.drq !== 1'b1 && lat < 8) begin @(negedge clk); lat++; end
        n_cmp++; if (bus.drq !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre_drq: got %b exp 1", bus.drq); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({bus.drq, bus.busy, bus.done, bus.err, bus.buf_write_hi, bus.buf_write_lo} !== 6'b0) begin n_bad++; $display("FAIL rstmid_flags: got %b exp 000000", {bus.drq, bus.busy, bus.done, bus.err, bus.buf_write_hi, bus.buf_write_lo}); end
        n_cmp++; if (bus.rd_data !== 16'h0 || bus.buf_read_addr !== '0 || bus.buf_write_addr !== '0) begin n_bad++; $display("FAIL rstmid_data: got %h %0d %0d exp 0 0 0", bus.rd_data, bus.buf_read_addr, bus.buf_write_addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_read(3, 10'd3, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.dir = 1'b0; bus.count = '0; bus.abort = 1'b0;
        bus.rd_strobe = 1'b0; bus.wr_strobe = 1'b0; bus.wr_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            stim[i]    = 16'($urandom);
            buf_mem[i] = stim[i];
            ref_mem[i] = stim[i];
        end
        test_reset();
        test_read_basic();
        test_write_basic();
        do_read(2, 10'd2, 1);
        test_full_buffer();
        test_err();
        test_start_busy();
        test_abort();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
